// File: rtl/enemy_palette_sequencer.sv
// enemy_palette_sequencer
// Rotates a fixed base palette across N_ENEMY colour channels. The rotation
// follows the low bits of the score, or steps on its own every CYCLE_FRAMES
// frames in auto mode. Each score change first flashes every enemy in
// FLASH_COLOUR for FLASH_FRAMES frames, then the new rotation is applied in
// one step so colours and offset always agree.
module enemy_palette_sequencer #(
  parameter int N_ENEMY = 4,
  parameter int COLOUR_W = 3,
  parameter int SCORE_W = 8,
  parameter logic [N_ENEMY*COLOUR_W-1:0] BASE_PALETTE = 12'b101_110_010_011,
  parameter logic [COLOUR_W-1:0] FLASH_COLOUR = 3'b111,
  parameter int FLASH_FRAMES = 4,
  parameter int CYCLE_FRAMES = 30,
  localparam int OFF_W = (N_ENEMY > 1) ? $clog2(N_ENEMY) : 1,
  localparam int PAL_W = N_ENEMY * COLOUR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic [SCORE_W-1:0] score,
  input  logic               auto_mode,
  output logic [PAL_W-1:0]   colours,
  output logic [OFF_W-1:0]   offset,
  output logic               flashing
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FLASH  = 2'd1,
    UPDATE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [OFF_W-1:0]   offset_q, offset_d;
  logic [OFF_W-1:0]   target_q, target_d;
  logic [PAL_W-1:0]   colours_q, colours_d;
  logic               flashing_q, flashing_d;
  logic [3:0]         flash_cnt_q, flash_cnt_d;
  logic [7:0]         cycle_cnt_q, cycle_cnt_d;
  logic [SCORE_W-1:0] score_q;
  logic               pending_q, pending_d;
  logic               change_s;

  // Enemy i takes base entry (i + off); power-of-two N makes the add wrap for free.
  function automatic logic [PAL_W-1:0] rotate(input logic [OFF_W-1:0] off);
    logic [PAL_W-1:0] r;
    logic [OFF_W-1:0] idx;
    r = '0;
    for (int i = 0; i < N_ENEMY; i++) begin
      idx = OFF_W'(i) + off;
      r[i*COLOUR_W +: COLOUR_W] = BASE_PALETTE[idx*COLOUR_W +: COLOUR_W];
    end
    return r;
  endfunction

  assign change_s = (score != score_q);

  // Next-state and output logic for the flash / update sequencer.
  always_comb begin
    state_d     = state_q;
    offset_d    = offset_q;
    colours_d   = colours_q;
    flashing_d  = flashing_q;
    flash_cnt_d = flash_cnt_q;
    cycle_cnt_d = cycle_cnt_q;
    pending_d   = 1'b0;

    // The most recent score always defines where the rotation ends up.
    if (change_s) begin
      target_d = score[OFF_W-1:0];
    end else begin
      target_d = target_q;
    end

    case (state_q)
      IDLE: begin
        // A change (fresh, or one seen during UPDATE) beats a coincident frame tick.
        if (change_s || pending_q) begin
          cycle_cnt_d = 8'd0;
          if (FLASH_FRAMES > 0) begin
            state_d     = FLASH;
            flashing_d  = 1'b1;
            colours_d   = {N_ENEMY{FLASH_COLOUR}};
            flash_cnt_d = 4'(FLASH_FRAMES);
          end else begin
            state_d = UPDATE;
          end
        end else if (auto_mode && frame_tick) begin
          if (cycle_cnt_q == 8'(CYCLE_FRAMES - 1)) begin
            cycle_cnt_d = 8'd0;
            offset_d    = offset_q + OFF_W'(1);
            colours_d   = rotate(offset_q + OFF_W'(1));
          end else begin
            cycle_cnt_d = cycle_cnt_q + 8'd1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      FLASH: begin
        // Flash length is fixed at entry; later score changes only move the target.
        if (frame_tick) begin
          flash_cnt_d = flash_cnt_q - 4'd1;
          if (flash_cnt_q == 4'd1) begin
            state_d    = UPDATE;
            flashing_d = 1'b0;
          end else begin
            state_d = FLASH;
          end
        end else begin
          state_d = FLASH;
        end
      end
      UPDATE: begin
        offset_d  = target_q;
        colours_d = rotate(target_q);
        state_d   = IDLE;
        pending_d = change_s;
      end
      default: begin
        state_d    = IDLE;
        flashing_d = 1'b0;
      end
    endcase

    if (!auto_mode) begin
      cycle_cnt_d = 8'd0;
    end else begin
      cycle_cnt_d = cycle_cnt_d;
    end
  end

  // State and output registers; reset also captures the score so release is quiet.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      offset_q    <= '0;
      target_q    <= '0;
      colours_q   <= BASE_PALETTE;
      flashing_q  <= 1'b0;
      flash_cnt_q <= 4'd0;
      cycle_cnt_q <= 8'd0;
      pending_q   <= 1'b0;
      score_q     <= score;
    end else begin
      state_q     <= state_d;
      offset_q    <= offset_d;
      target_q    <= target_d;
      colours_q   <= colours_d;
      flashing_q  <= flashing_d;
      flash_cnt_q <= flash_cnt_d;
      cycle_cnt_q <= cycle_cnt_d;
      pending_q   <= pending_d;
      score_q     <= score;
    end
  end

  assign colours  = colours_q;
  assign offset   = offset_q;
  assign flashing = flashing_q;

endmodule

// File: tb/tb_enemy_palette_sequencer.sv
// Bench for enemy_palette_sequencer: instance A uses default timing
// (4-frame flash, 30-frame auto step), instance B has no flash and a 3-frame
// auto step. Expected output states are queued just before the stimulus that
// should cause them, with the cycle they must appear on; the monitor pops one
// entry on every change of a DUT's outputs.
module tb_enemy_palette_sequencer;

  localparam logic [11:0] BASE  = 12'b101_110_010_011;
  localparam logic [11:0] ROT1  = 12'b011_101_110_010;
  localparam logic [11:0] ROT2  = 12'b010_011_101_110;
  localparam logic [11:0] ROT3  = 12'b110_010_011_101;
  localparam logic [11:0] FLASHC = 12'hFFF;

  typedef struct {
    logic [11:0] col;
    logic [1:0]  off;
    logic        fl;
    int          due;
    string       nm;
  } exp_t;

  logic clk = 1'b0;
  logic reset_a, frame_tick_a, auto_a;
  logic reset_b, frame_tick_b, auto_b;
  logic [7:0] score_a, score_b;
  logic [11:0] colours_a, colours_b;
  logic [1:0] offset_a, offset_b;
  logic flashing_a, flashing_b;

  exp_t qa[$];
  exp_t qb[$];
  int total = 0;
  int bad = 0;
  int cyc_n = 0;
  int drain_seq = 0;
  int drain_seen = 0;
  int drain_wait = 0;
  string drain_nm = "";
  logic [14:0] prev_a = 'x;
  logic [14:0] prev_b = 'x;

  enemy_palette_sequencer dut_a (
    .clk(clk), .reset(reset_a), .frame_tick(frame_tick_a), .score(score_a),
    .auto_mode(auto_a), .colours(colours_a), .offset(offset_a), .flashing(flashing_a)
  );

  enemy_palette_sequencer #(.FLASH_FRAMES(0), .CYCLE_FRAMES(3)) dut_b (
    .clk(clk), .reset(reset_b), .frame_tick(frame_tick_b), .score(score_b),
    .auto_mode(auto_b), .colours(colours_b), .offset(offset_b), .flashing(flashing_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Monitor: every output change pops and checks the next expected state.
  always @(negedge clk) begin
    exp_t e;
    if ({colours_a, offset_a, flashing_a} !== prev_a) begin
      prev_a = {colours_a, offset_a, flashing_a};
      total++;
      if (qa.size() == 0) begin
        bad++;
        $display("FAIL A_unexpected got col=%b off=%0d fl=%b cyc=%0d", colours_a, offset_a, flashing_a, cyc_n);
      end else begin
        e = qa.pop_front();
        if (colours_a !== e.col || offset_a !== e.off || flashing_a !== e.fl || cyc_n != e.due) begin
          bad++;
          $display("FAIL %s got col=%b off=%0d fl=%b cyc=%0d exp col=%b off=%0d fl=%b cyc=%0d",
                   e.nm, colours_a, offset_a, flashing_a, cyc_n, e.col, e.off, e.fl, e.due);
        end
      end
    end
    if ({colours_b, offset_b, flashing_b} !== prev_b) begin
      prev_b = {colours_b, offset_b, flashing_b};
      total++;
      if (qb.size() == 0) begin
        bad++;
        $display("FAIL B_unexpected got col=%b off=%0d fl=%b cyc=%0d", colours_b, offset_b, flashing_b, cyc_n);
      end else begin
        e = qb.pop_front();
        if (colours_b !== e.col || offset_b !== e.off || flashing_b !== e.fl || cyc_n != e.due) begin
          bad++;
          $display("FAIL %s got col=%b off=%0d fl=%b cyc=%0d exp col=%b off=%0d fl=%b cyc=%0d",
                   e.nm, colours_b, offset_b, flashing_b, cyc_n, e.col, e.off, e.fl, e.due);
        end
      end
    end
    if (drain_seen != drain_seq) begin
      if (qa.size() == 0 && qb.size() == 0) begin
        total++;
        drain_seen = drain_seq;
        drain_wait = 0;
      end else if (drain_wait >= 20) begin
        total++;
        bad++;
        $display("FAIL %s pending got a=%0d b=%0d exp a=0 b=0", drain_nm, qa.size(), qb.size());
        drain_seen = drain_seq;
        drain_wait = 0;
      end else begin
        drain_wait++;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_a(input logic [11:0] col, input logic [1:0] off, input logic fl,
                        input int lat, input string nm);
    exp_t e;
    e.col = col; e.off = off; e.fl = fl; e.due = cyc_n + lat; e.nm = nm;
    qa.push_back(e);
  endtask

  task automatic push_b(input logic [11:0] col, input logic [1:0] off, input logic fl,
                        input int lat, input string nm);
    exp_t e;
    e.col = col; e.off = off; e.fl = fl; e.due = cyc_n + lat; e.nm = nm;
    qb.push_back(e);
  endtask

  task automatic drain(input string nm);
    drain_nm = nm;
    drain_seq++;
    for (int i = 0; i < 40 && drain_seen != drain_seq; i++) cyc(1);
  endtask

  task automatic tick_a();
    frame_tick_a = 1'b1;
    cyc(1);
    frame_tick_a = 1'b0;
    cyc(2);
  endtask

  task automatic tick_b();
    frame_tick_b = 1'b1;
    cyc(1);
    frame_tick_b = 1'b0;
    cyc(2);
  endtask

  initial begin
    reset_a = 1'b1; frame_tick_a = 1'b0; auto_a = 1'b0; score_a = 8'd5;
    reset_b = 1'b1; frame_tick_b = 1'b0; auto_b = 1'b0; score_b = 8'd0;
    push_a(BASE, 2'd0, 1'b0, 1, "a_reset");
    push_b(BASE, 2'd0, 1'b0, 1, "b_reset");
    cyc(3);
    // Reset released with score=5: no flash, base palette held.
    reset_a = 1'b0; reset_b = 1'b0;
    cyc(10);
    drain("t1_idle");

    // Score 0 -> 1: flash, four ticks, then rotation 1.
    reset_a = 1'b1; score_a = 8'd0;
    cyc(2);
    reset_a = 1'b0;
    cyc(2);
    push_a(FLASHC, 2'd0, 1'b1, 1, "t2_flash_on");
    score_a = 8'd1;
    cyc(3);
    drain("t2_entry");
    repeat (3) tick_a();
    drain("t2_hold");
    push_a(FLASHC, 2'd0, 1'b0, 1, "t2_flash_off");
    push_a(ROT1, 2'd1, 1'b0, 2, "t2_rot1");
    tick_a();
    drain("t2_update");

    // Change during flash moves the target but does not extend the flash.
    push_a(FLASHC, 2'd1, 1'b1, 1, "t3_flash_on");
    score_a = 8'd9;
    cyc(3);
    repeat (2) tick_a();
    score_a = 8'd2;
    cyc(3);
    tick_a();
    drain("t3_hold");
    push_a(FLASHC, 2'd1, 1'b0, 1, "t3_flash_off");
    push_a(ROT2, 2'd2, 1'b0, 2, "t3_rot2");
    tick_a();
    drain("t3_update");

    // Reset in the middle of a flash.
    push_a(FLASHC, 2'd2, 1'b1, 1, "t5_flash_on");
    score_a = 8'd7;
    cyc(3);
    tick_a();
    drain("t5_mid");
    push_a(BASE, 2'd0, 1'b0, 1, "t5_reset");
    reset_a = 1'b1;
    cyc(1);
    reset_a = 1'b0;
    cyc(8);
    drain("t5_after");

    // Auto mode on instance B: a step every third tick, no flash.
    auto_b = 1'b1;
    cyc(1);
    for (int k = 1; k <= 12; k++) begin
      if (k == 3)  push_b(ROT1, 2'd1, 1'b0, 1, "t4_step1");
      if (k == 6)  push_b(ROT2, 2'd2, 1'b0, 1, "t4_step2");
      if (k == 9)  push_b(ROT3, 2'd3, 1'b0, 1, "t4_step3");
      if (k == 12) push_b(BASE, 2'd0, 1'b0, 1, "t4_step0");
      tick_b();
    end
    drain("t4_auto");

    // No-flash score path, including the 3 -> 4 wrap.
    auto_b = 1'b0;
    cyc(2);
    push_b(ROT3, 2'd3, 1'b0, 2, "t6_score3");
    score_b = 8'd3;
    cyc(4);
    drain("t6_pre");
    push_b(BASE, 2'd0, 1'b0, 2, "t6_wrap");
    score_b = 8'd4;
    cyc(6);
    drain("t6_wrap_done");

    cyc(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
